sram_bank_ctrl: RTL
===================

# sram_bank_ctrl

Parametrised multi-bank asynchronous-SRAM controller that bridges a single valid/ready request port from the CPU memory stage to BANKS independent SRAM chips (BaseRAM/ExtRAM on the Thinpad board, BANKS=2). It generates chip-select, output-enable, write-enable and byte-enable strobes with programmable wait states. One transaction is in flight at a time. The data bus is split into o/i/oe vectors; tristating happens in thinpad_top.

## Interface
Parameters:
- DATA_W, 32, SRAM word width (multiple of 8)
- ADDR_W, 20, word address width per bank
- BANKS, 2, number of banks (1..4)
- RD_WAIT, 1, extra read cycles with oe_n low before sampling (0..7)
- WR_WAIT, 2, cycles we_n is held low (1..7)

Ports (BW = max(1,$clog2(BANKS)), NB = DATA_W/8):
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, accepts request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  BW+ADDR_W  {bank, word address}
- req_be  in  NB  byte enables for writes, active-high
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes/errors)
- rsp_err  out  1  bank index ≥ BANKS
- ram_addr  out  BANKS*ADDR_W  per-bank address
- ram_dq_o  out  BANKS*DATA_W  per-bank write data
- ram_dq_i  in  BANKS*DATA_W  per-bank read data
- ram_dq_oe  out  BANKS  drive data bus
- ram_ce_n, ram_oe_n, ram_we_n  out  BANKS each  active-low strobes
- ram_be_n  out  BANKS*NB  active-low byte enables

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, RSP.
- IDLE: req_ready=1. On req_valid: register addr/be/wdata/we, decode bank. Invalid bank → RSP with rsp_err=1, rsp_rdata=0, no strobes.
- RD: selected ce_n=0, oe_n=0, be_n=all 0, dq_oe=0; lasts RD_WAIT+1 cycles; ram_dq_i of the selected bank is sampled on the last cycle; → RSP.
- WR_SETUP (1 cycle): ce_n=0, we_n=1, be_n=~req_be, dq_oe=1, data driven → WR_PULSE.
- WR_PULSE (WR_WAIT cycles): we_n=0 → WR_HOLD.
- WR_HOLD (1 cycle): we_n=1, ce_n=0, data still driven → RSP.
- RSP: rsp_valid=1, all strobes high, dq_oe=0; when rsp_ready=1 → IDLE.
- Unselected banks always have ce_n/oe_n/we_n/be_n all 1 and dq_oe=0. Addresses and data are held stable for the entire access.
- All outputs are registered.

## Timing
- Reset values (asserted asynchronously): state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; all ce_n/oe_n/we_n/be_n=1; dq_oe=0; ram_addr=0; ram_dq_o=0.
- Request accepted at edge 0 → read rsp_valid at edge RD_WAIT+2 → write rsp_valid at edge WR_WAIT+3 → error rsp_valid at edge 1.
- req_ready=0 from edge 0 until the edge after the RSP handshake. There is no back-to-back acceptance in the RSP-exit cycle.
- rsp_rdata, rsp_err remain stable while rsp_valid=1 and rsp_ready=0.
- Reset asserted mid-write: we_n and ce_n return high asynchronously. The access is lost and no response is issued.

## Configuration
- SRAM_CTRL_BYTE_SWAP_EN defined: write data and read data are byte-reversed per word, and req_be is reversed to match. This serves big-endian-loaded memory images.
- Undefined: data and byte enables pass straight through.

## Structure
- Package sram_ctrl_pkg: state enum type, and a bswap function parameterised on NB.
- One sub-module, sram_bank_mux: decodes the bank index and fans strobes out to, and read data in from, BANKS banks. It is combinational plus a registered strobe output.

## Test plan
- Defaults: write bank0 addr 0x00010, be=4'b1111, data 0x12345678, then read it back. Expect rsp at +5 and +3 cycles; rdata 0x12345678; we_n low exactly 2 cycles.
- Partial write: be=4'b0010, data 0xAABBCCDD over 0xFFFFFFFF, then read. Expect ram_be_n=4'b1101; read returns 0xFFFFCCFF.
- Bank 1 access: verify bank0 strobes stay 1 throughout and ext-side data is returned.
- BANKS=3, bank index 3 → rsp_err=1 at +1 cycle, rdata 0, no ce_n activity.
- Hold rsp_ready=0 for 10 cycles → rsp_valid and rdata stable, req_ready=0. Separately, rst_n low during WR_PULSE → we_n=1 immediately, rsp_valid=0.
- With SRAM_CTRL_BYTE_SWAP_EN, write 0x11223344 → ram_dq_o=0x44332211; read returns 0x11223344.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// Module   : sram_ctrl_pkg
// Brief    : Shared FSM state type and byte-order helpers for the SRAM bank controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_RSP      = 3'd5
    } state_t;

    localparam int C_MAX_DW = 256;
    localparam int C_MAX_NB = C_MAX_DW / 8;

    // Reverses the lowest nb bytes of d; bytes above nb come back as zero.
    function automatic logic [C_MAX_DW-1:0] bswap(input logic [C_MAX_DW-1:0] d, input int nb);
        logic [C_MAX_DW-1:0] r;
        r = '0;
        for (int i = 0; i < C_MAX_NB; i++) begin
            if (i < nb) r[8*i +: 8] = d[8*(nb-1-i) +: 8];
        end
        return r;
    endfunction

    // Byte-enable companion of bswap: reverses the lowest n bits.
    function automatic logic [C_MAX_NB-1:0] bitrev(input logic [C_MAX_NB-1:0] b, input int n);
        logic [C_MAX_NB-1:0] r;
        r = '0;
        for (int i = 0; i < C_MAX_NB; i++) begin
            if (i < n) r[i] = b[n-1-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_bank_mux.sv
// ============================================================================
// Module   : sram_bank_mux
// Brief    : Bank decode, registered per-bank strobe fan-out and read-data select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank_mux
    import sram_ctrl_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int BANKS  = 2,
    parameter  int BW     = 1,
    localparam int NB     = DATA_W / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BW-1:0]           i_req_bank,
    output logic                    o_req_err,
    input  state_t                  i_state,
    input  logic [BW-1:0]           i_bank,
    input  logic [NB-1:0]           i_be,
    input  logic [BANKS*DATA_W-1:0] i_ram_dq_i,
    output logic [DATA_W-1:0]       o_rdata,
    output logic [BANKS-1:0]        o_ram_ce_n,
    output logic [BANKS-1:0]        o_ram_oe_n,
    output logic [BANKS-1:0]        o_ram_we_n,
    output logic [BANKS-1:0]        o_ram_dq_oe,
    output logic [BANKS*NB-1:0]     o_ram_be_n
);

    logic [BANKS-1:0]    w_sel;
    logic                w_rd;
    logic                w_wr;
    logic                w_pulse;
    logic [BANKS-1:0]    r_ce_n;
    logic [BANKS-1:0]    r_oe_n;
    logic [BANKS-1:0]    r_we_n;
    logic [BANKS-1:0]    r_dq_oe;
    logic [BANKS*NB-1:0] r_be_n;

    always_comb begin
        w_sel = '0;
        for (int b = 0; b < BANKS; b++) begin
            w_sel[b] = (i_bank == BW'(b));
        end
    end

    assign w_rd      = (i_state == ST_RD);
    assign w_wr      = (i_state == ST_WR_SETUP) || (i_state == ST_WR_PULSE) || (i_state == ST_WR_HOLD);
    assign w_pulse   = (i_state == ST_WR_PULSE);
    assign o_req_err = ({1'b0, i_req_bank} >= (BW+1)'(BANKS));

    // Strobes are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce_n  <= '1;
            r_oe_n  <= '1;
            r_we_n  <= '1;
            r_dq_oe <= '0;
            r_be_n  <= '1;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                r_ce_n[b]  <= !(w_sel[b] && (w_rd || w_wr));
                r_oe_n[b]  <= !(w_sel[b] && w_rd);
                r_we_n[b]  <= !(w_sel[b] && w_pulse);
                r_dq_oe[b] <= w_sel[b] && w_wr;
                if (w_sel[b] && w_rd)
                    r_be_n[b*NB +: NB] <= '0;
                else if (w_sel[b] && w_wr)
                    r_be_n[b*NB +: NB] <= ~i_be;
                else
                    r_be_n[b*NB +: NB] <= '1;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_sel[b]) o_rdata = i_ram_dq_i[b*DATA_W +: DATA_W];
        end
    end

    assign o_ram_ce_n  = r_ce_n;
    assign o_ram_oe_n  = r_oe_n;
    assign o_ram_we_n  = r_we_n;
    assign o_ram_dq_oe = r_dq_oe;
    assign o_ram_be_n  = r_be_n;

endmodule

`default_nettype wire

// File: rtl/sram_bank_ctrl.sv
// ============================================================================
// Module   : sram_bank_ctrl
// Brief    : Multi-bank async-SRAM controller with programmable wait states.
//            Optional SRAM_CTRL_BYTE_SWAP_EN byte-reverses data and byte enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 20,
    parameter  int BANKS   = 2,
    parameter  int RD_WAIT = 1,
    parameter  int WR_WAIT = 2,
    localparam int BW      = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int NB      = DATA_W / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [BW+ADDR_W-1:0]    i_req_addr,
    input  logic [NB-1:0]           i_req_be,
    input  logic [DATA_W-1:0]       i_req_wdata,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_W-1:0]       o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic [BANKS*ADDR_W-1:0] o_ram_addr,
    output logic [BANKS*DATA_W-1:0] o_ram_dq_o,
    input  logic [BANKS*DATA_W-1:0] i_ram_dq_i,
    output logic [BANKS-1:0]        o_ram_dq_oe,
    output logic [BANKS-1:0]        o_ram_ce_n,
    output logic [BANKS-1:0]        o_ram_oe_n,
    output logic [BANKS-1:0]        o_ram_we_n,
    output logic [BANKS*NB-1:0]     o_ram_be_n
);

    localparam logic [2:0] c_rd_last = 3'(RD_WAIT);
    localparam logic [2:0] c_wr_last = 3'(WR_WAIT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_cnt;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_we;
    logic                r_err;
    logic [BW-1:0]       r_bank;
    logic [ADDR_W-1:0]   r_addr;
    logic [NB-1:0]       r_be;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_accept;
    logic                w_req_err;
    logic [DATA_W-1:0]   w_wdata;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_mux_rdata;
    logic [DATA_W-1:0]   w_rdata;

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && i_req_valid;

`ifdef SRAM_CTRL_BYTE_SWAP_EN
    assign w_wdata = DATA_W'(bswap(C_MAX_DW'(i_req_wdata), NB));
    assign w_be    = NB'(bitrev(C_MAX_NB'(i_req_be), NB));
    assign w_rdata = DATA_W'(bswap(C_MAX_DW'(w_mux_rdata), NB));
`else
    assign w_wdata = i_req_wdata;
    assign w_be    = i_req_be;
    assign w_rdata = w_mux_rdata;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)     w_state_nxt = ST_RSP;
                    else if (i_req_we) w_state_nxt = ST_WR_SETUP;
                    else               w_state_nxt = ST_RD;
                end
            end
            ST_RD:       if (r_cnt == c_rd_last) w_state_nxt = ST_RSP;
            ST_WR_SETUP: w_state_nxt = ST_WR_PULSE;
            ST_WR_PULSE: if (r_cnt == c_wr_last) w_state_nxt = ST_WR_HOLD;
            ST_WR_HOLD:  w_state_nxt = ST_RSP;
            ST_RSP:      if (r_rsp_valid && i_rsp_ready) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state) ? 3'd0 : r_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_bank  <= '0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= i_req_we;
            r_err   <= w_req_err;
            r_bank  <= i_req_addr[ADDR_W +: BW];
            r_addr  <= i_req_addr[ADDR_W-1:0];
            r_be    <= w_be;
            r_wdata <= w_wdata;
        end
    end

    // Response is raised one cycle after entering RSP, which is also the last
    // cycle oe_n is still low, so the read data is captured at that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_req_ready <= (r_state == ST_IDLE) && !w_accept;
            if (r_state == ST_RSP && !r_rsp_valid) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (r_we || r_err) ? '0 : w_rdata;
            end else if (r_rsp_valid && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    sram_bank_mux #(
        .DATA_W (DATA_W),
        .BANKS  (BANKS),
        .BW     (BW)
    ) u_mux (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_bank  (i_req_addr[ADDR_W +: BW]),
        .o_req_err   (w_req_err),
        .i_state     (r_state),
        .i_bank      (r_bank),
        .i_be        (r_be),
        .i_ram_dq_i  (i_ram_dq_i),
        .o_rdata     (w_mux_rdata),
        .o_ram_ce_n  (o_ram_ce_n),
        .o_ram_oe_n  (o_ram_oe_n),
        .o_ram_we_n  (o_ram_we_n),
        .o_ram_dq_oe (o_ram_dq_oe),
        .o_ram_be_n  (o_ram_be_n)
    );

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_ram_addr  = {BANKS{r_addr}};
    assign o_ram_dq_o  = {BANKS{r_wdata}};

endmodule

`default_nettype wire
